// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of fetch and load/store ports onto one word-addressed memory; req->gnt same cycle, gnt->vld 3 cycles with a 1-cycle memory.
// One transaction in flight; other requesters wait, holding req, until the next IDLE cycle. A silent memory is aborted after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_vld,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_strb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_vld,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_rrdy,
    output logic [ADDR_W-1:0] m_raddr,
    output logic [DATA_W-1:0] m_rwdata,
    output logic              m_rwen,
    output logic [3:0]        m_rwstrobe,
    input  logic              m_rvld,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t              state;
    state_t              state_nxt;
    logic                last_d;
    logic                own_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          strb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [15:0]         cnt;
    logic                gnt_i;
    logic                gnt_d;
    logic                done_ok;
    logic                done_to;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                if (last_d) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else if (i_req) begin
                gnt_i = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end
        end
    end

    // Grants are combinational, so they are masked explicitly while reset is held.
    assign i_gnt = gnt_i & ~rstn;
    assign d_gnt = gnt_d & ~rstn;

    assign done_ok = (state == WAIT) && m_rvld;
    assign done_to = (state == WAIT) && !m_rvld && (cnt == TO_LIMIT);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_i || gnt_d) state_nxt = WAIT;
            WAIT: if (done_ok || done_to) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        m_rrdy     = 1'b0;
        m_raddr    = '0;
        m_rwen     = 1'b0;
        m_rwstrobe = 4'b0;
        m_rwdata   = '0;
        if (state == WAIT) begin
            busy    = 1'b1;
            m_rrdy  = 1'b1;
            m_raddr = addr_q;
            if (we_q) begin
                m_rwen     = 1'b1;
                m_rwstrobe = strb_q;
                m_rwdata   = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            last_d  <= 1'b1;
            own_d   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= 4'b0;
            wdata_q <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            i_vld   <= 1'b0;
            d_vld   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_vld   <= (done_ok || done_to) && !own_d;
            d_vld   <= (done_ok || done_to) && own_d;
            // Aborted transactions and writes return zero data.
            i_rdata <= (done_ok && !own_d) ? m_rdata : '0;
            d_rdata <= (done_ok && own_d && !we_q) ? m_rdata : '0;
            if (done_to) begin
                err <= 1'b1;
            end
            if (gnt_i || gnt_d) begin
                own_d   <= gnt_d;
                last_d  <= gnt_d;
                addr_q  <= gnt_d ? d_addr : i_addr;
                we_q    <= gnt_d && d_we;
                strb_q  <= gnt_d ? d_strb : 4'b0;
                wdata_q <= gnt_d ? d_wdata : '0;
                cnt     <= '0;
            end else if ((state == WAIT) && !m_rvld && (cnt != TO_LIMIT)) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random and directed traffic against a 1-cycle memory model,
// with a transaction-level reference (memory image, arbitration order, completion cycle) feeding a scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          i_req, i_gnt, i_vld;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_vld;
    logic [3:0]    d_strb;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_rrdy, m_rwen, m_rvld, busy, err;
    logic [AW-1:0] m_raddr;
    logic [DW-1:0] m_rwdata, m_rdata;
    logic [3:0]    m_rwstrobe;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_vld(i_vld), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_vld(d_vld), .d_rdata(d_rdata),
        .m_rrdy(m_rrdy), .m_raddr(m_raddr), .m_rwdata(m_rwdata), .m_rwen(m_rwen),
        .m_rwstrobe(m_rwstrobe), .m_rvld(m_rvld), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    req_t        iq[$];
    req_t        dq[$];
    rsp_t        sb_i[$];
    rsp_t        sb_d[$];
    bit [31:0]   dev_mem[bit [31:0]];
    bit [31:0]   ref_mem[bit [31:0]];
    bit          mem_en = 1'b1;
    int          gap_max = 0;
    bit          i_drv_busy = 1'b0;
    bit          d_drv_busy = 1'b0;

    // Reference model state: whole transactions, not RTL state.
    bit          ref_last_d = 1'b1;
    int          next_free = 0;
    int          w_start = 0;
    int          w_end = 0;
    logic [31:0] w_addr, w_wdata;
    logic        w_we;
    logic [3:0]  w_strb;
    int          err_cyc = 1 << 30;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_dev(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 32'h0;
    endfunction

    task automatic init_mem(input logic [31:0] a, input logic [31:0] v);
        dev_mem[a] = v;
        ref_mem[a] = v;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Single-cycle memory: answers one cycle after it sees m_rrdy, junk data when not a read.
    initial begin
        bit          pend;
        bit          wflag;
        logic [31:0] rd;
        m_rvld  = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            pend  = mem_en && m_rrdy && !m_rvld && !rstn;
            wflag = m_rwen;
            rd    = 32'h0;
            if (pend) begin
                if (m_rwen) dev_mem[m_raddr] = merge(rd_dev(m_raddr), m_rwdata, m_rwstrobe);
                else rd = rd_dev(m_raddr);
            end
            @(posedge clk);
            #1;
            m_rvld  = pend;
            m_rdata = (pend && !wflag) ? rd : $urandom;
        end
    end

    initial begin
        req_t r;
        int   n;
        i_req  = 1'b0;
        i_addr = '0;
        forever begin
            if (iq.size() == 0) begin
                @(posedge clk);
                #1;
            end else begin
                r = iq.pop_front();
                i_drv_busy = 1'b1;
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
                i_addr = r.addr;
                i_req  = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!i_gnt && n < 200);
                if (!i_gnt) check("i_gnt_wait", i_gnt, 1);
                @(posedge clk);
                #1;
                i_req = 1'b0;
                i_drv_busy = 1'b0;
            end
        end
    end

    initial begin
        req_t r;
        int   n;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_strb  = 4'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            if (dq.size() == 0) begin
                @(posedge clk);
                #1;
            end else begin
                r = dq.pop_front();
                d_drv_busy = 1'b1;
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
                d_addr  = r.addr;
                d_we    = r.we;
                d_strb  = r.strb;
                d_wdata = r.wdata;
                d_req   = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!d_gnt && n < 200);
                if (!d_gnt) check("d_gnt_wait", d_gnt, 1);
                @(posedge clk);
                #1;
                d_req = 1'b0;
                d_drv_busy = 1'b0;
            end
        end
    end

    // Monitor: checks bus, grants and responses every cycle against the reference.
    initial begin
        rsp_t        e;
        bit          free, eg_i, eg_d, eb, wr;
        logic [31:0] a, dat;
        int          done;
        forever begin
            @(negedge clk);
            if (rstn) begin
                sb_i.delete();
                sb_d.delete();
                ref_last_d = 1'b1;
                next_free  = 0;
                w_start    = 0;
                w_end      = 0;
                err_cyc    = 1 << 30;
            end else begin
                if (i_vld) begin
                    if (sb_i.size() == 0) check("i_vld_spurious", i_vld, 0);
                    else begin
                        e = sb_i.pop_front();
                        check("i_rdata", i_rdata, e.data);
                        check("i_vld_cycle", cyc, e.cyc);
                    end
                end else if (sb_i.size() != 0 && cyc > sb_i[0].cyc) begin
                    check("i_vld_missing", i_vld, 1);
                    void'(sb_i.pop_front());
                end
                if (d_vld) begin
                    if (sb_d.size() == 0) check("d_vld_spurious", d_vld, 0);
                    else begin
                        e = sb_d.pop_front();
                        check("d_rdata", d_rdata, e.data);
                        check("d_vld_cycle", cyc, e.cyc);
                    end
                end else if (sb_d.size() != 0 && cyc > sb_d[0].cyc) begin
                    check("d_vld_missing", d_vld, 1);
                    void'(sb_d.pop_front());
                end

                eb = (cyc >= w_start) && (cyc < w_end);
                check("busy", busy, eb);
                check("m_rrdy", m_rrdy, eb);
                check("m_raddr", m_raddr, eb ? w_addr : 32'h0);
                check("m_rwen", m_rwen, eb && w_we);
                check("m_rwstrobe", m_rwstrobe, (eb && w_we) ? w_strb : 4'h0);
                check("m_rwdata", m_rwdata, (eb && w_we) ? w_wdata : 32'h0);
                check("err", err, cyc >= err_cyc);

                free = cyc >= next_free;
                eg_i = free && i_req && (!d_req || ref_last_d);
                eg_d = free && d_req && (!i_req || !ref_last_d);
                if (i_req || d_req || i_gnt || d_gnt) check("grant", {i_gnt, d_gnt}, {eg_i, eg_d});
                if (eg_i || eg_d) begin
                    a  = eg_d ? d_addr : i_addr;
                    wr = eg_d && d_we;
                    if (mem_en) begin
                        dat = wr ? 32'h0 : rd_ref(a);
                        if (wr) ref_mem[a] = merge(rd_ref(a), d_wdata, d_strb);
                        done = cyc + 3;
                    end else begin
                        dat  = 32'h0;
                        done = cyc + TO + 2;
                        if (err_cyc > done) err_cyc = done;
                    end
                    e.data = dat;
                    e.cyc  = done;
                    if (eg_d) sb_d.push_back(e);
                    else sb_i.push_back(e);
                    ref_last_d = eg_d;
                    next_free  = done;
                    w_start    = cyc + 1;
                    w_end      = done;
                    w_addr     = a;
                    w_we       = wr;
                    w_strb     = d_strb;
                    w_wdata    = d_wdata;
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || i_drv_busy || d_drv_busy ||
                sb_i.size() != 0 || sb_d.size() != 0 || busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (n >= limit) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait: traffic still pending after %0d cycles", limit);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b0;
    endtask

    task automatic push_d(input logic we, input logic [3:0] strb, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r.we = we;
        r.strb = strb;
        r.addr = a;
        r.wdata = wd;
        dq.push_back(r);
    endtask

    task automatic push_i(input logic [31:0] a);
        req_t r;
        r.we = 1'b0;
        r.strb = 4'b0;
        r.addr = a;
        r.wdata = 32'h0;
        iq.push_back(r);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 32; k++) init_mem(k, $urandom);
        init_mem(32'h10, 32'h0050_0093);
        init_mem(32'h20, 32'hDEAD_BEEF);
        init_mem(32'h100, 32'hAABB_CCDD);

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {i_gnt, d_gnt, i_vld, d_vld, m_rrdy, m_rwen, busy, err}, 8'h00);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rst_mbus", {m_raddr, m_rwdata}, 64'h0);
        check("rst_strobe", m_rwstrobe, 4'h0);

        push_i(32'h10);
        @(negedge clk);
        @(negedge clk);
        check("gnt_in_reset", i_gnt, 0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        wait_idle(200);

        push_d(1'b1, 4'b0011, 32'h100, 32'h1122_3344);
        push_d(1'b0, 4'b0000, 32'h100, 32'h0);
        wait_idle(200);

        do_reset();
        push_i(32'h10);
        push_i(32'h11);
        push_d(1'b0, 4'b0, 32'h100, 32'h0);
        push_d(1'b0, 4'b0, 32'h0, 32'h0);
        wait_idle(200);

        for (int k = 0; k < 5; k++) push_d(1'b0, 4'b0, k, 32'h0);
        wait_idle(200);

        mem_en = 1'b0;
        push_i(32'h20);
        wait_idle(200);
        mem_en = 1'b1;
        push_i(32'h20);
        push_d(1'b1, 4'b1111, 32'h5, 32'h0BAD_F00D);
        wait_idle(200);

        gap_max = 2;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 1) == 1) push_i($urandom_range(0, 31));
            else push_d($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 31), $urandom);
        end
        wait_idle(5000);
        gap_max = 0;

        push_d(1'b0, 4'b0, 32'h3, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_gnt && n < 100);
        if (!d_gnt) check("midrst_gnt", d_gnt, 1);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check("midrst_m_rrdy", m_rrdy, 0);
        check("midrst_busy", busy, 0);
        check("midrst_d_vld", d_vld, 0);
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        push_d(1'b0, 4'b0, 32'h4, 32'h0);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
